// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection/control for the 5-stage 16-bit pipeline: load-use stalls and branch/jump flushes.
// Optional macro HZD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W        = 3,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] IFID_RSaddr_i,
  input  logic [REG_ADDR_W-1:0] IFID_RTaddr_i,
  input  logic                  IFID_useRS_i,
  input  logic                  IFID_useRT_i,
  input  logic                  IDEX_memRead_i,
  input  logic [REG_ADDR_W-1:0] IDEX_RTaddr_i,
  input  logic                  branch_taken_i,
  input  logic                  jump_i,
`ifdef HZD_PERF_CNT_EN
  output logic [15:0]           stall_cnt_o,
  output logic [15:0]           flush_cnt_o,
`endif
  output logic                  PCwrite_o,
  output logic                  IFID_write_o,
  output logic                  IFID_flush_o,
  output logic                  DHZ_o,
  output logic                  CHZ_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Reload values are only meaningful when the matching cycle count exceeds 1.
  localparam logic [2:0] STALL_RELOAD = (LOAD_STALL_CYCLES > 1) ? 3'(LOAD_STALL_CYCLES - 2) : 3'd0;
  localparam logic [2:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1)      ? 3'(FLUSH_CYCLES - 2)      : 3'd0;
  localparam bit         MULTI_STALL  = (LOAD_STALL_CYCLES > 1);
  localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  state_e     r_state;
  logic [2:0] r_cnt;

  state_e     w_nxt_state;
  logic [2:0] w_nxt_cnt;
  logic       w_lu;
  logic       w_ch;
  logic       w_pc_we;
  logic       w_ifid_we;
  logic       w_ifid_flush;
  logic       w_dhz;
  logic       w_chz;

  assign w_lu = IDEX_memRead_i && (IDEX_RTaddr_i != '0) &&
                ((IFID_useRS_i && (IFID_RSaddr_i == IDEX_RTaddr_i)) ||
                 (IFID_useRT_i && (IFID_RTaddr_i == IDEX_RTaddr_i)));
  assign w_ch = branch_taken_i || jump_i;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cnt    = r_cnt;
    w_pc_we      = 1'b1;
    w_ifid_we    = 1'b1;
    w_ifid_flush = 1'b0;
    w_dhz        = 1'b0;
    w_chz        = 1'b0;

    if (w_ch) begin
      // Control hazards win everywhere: a stalled instruction behind a taken branch is wrong-path.
      w_ifid_flush = 1'b1;
      w_chz        = 1'b1;
      w_nxt_state  = MULTI_FLUSH ? ST_FLUSH : ST_IDLE;
      w_nxt_cnt    = FLUSH_RELOAD;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_lu) begin
            w_pc_we     = 1'b0;
            w_ifid_we   = 1'b0;
            w_dhz       = 1'b1;
            w_nxt_state = MULTI_STALL ? ST_STALL : ST_IDLE;
            w_nxt_cnt   = STALL_RELOAD;
          end
        end
        ST_STALL: begin
          w_pc_we   = 1'b0;
          w_ifid_we = 1'b0;
          w_dhz     = 1'b1;
          if (r_cnt == 3'd0) w_nxt_state = ST_IDLE;
          else               w_nxt_cnt   = r_cnt - 3'd1;
        end
        ST_FLUSH: begin
          w_ifid_flush = 1'b1;
          w_chz        = 1'b1;
          if (r_cnt == 3'd0) w_nxt_state = ST_IDLE;
          else               w_nxt_cnt   = r_cnt - 3'd1;
        end
        default: begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = 3'd0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // Outputs are forced low for as long as reset is held, not just at the next edge.
  assign PCwrite_o    = rst_n & w_pc_we;
  assign IFID_write_o = rst_n & w_ifid_we;
  assign IFID_flush_o = rst_n & w_ifid_flush;
  assign DHZ_o        = rst_n & w_dhz;
  assign CHZ_o        = rst_n & w_chz;

`ifdef HZD_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_dhz && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_chz && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
